tcp_tx_ctrl: RTL and testbench

Control FSM for the TCP TX protocol-calc datapath. It accepts one scheduler request at a time, issues the four per-flow state reads, and pulses the datapath store strobes in order. It then retires the flow by writing back the next TX state, sending the scheduler flag-clear command and, when the datapath says a packet exists, handing the header/payload descriptor downstream. It sits between the TX scheduler and the per-flow state memories, next to the TX datapath.

---
 rtl/tcp_pkg.sv | 22 ++
 rtl/val_rdy_done_tracker.sv | 39 +++
 rtl/tcp_tx_ctrl.sv | 120 ++++++++++++
 tb/tb_tcp_tx_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// Shared types and constants for the TCP TX protocol-calc control path.
// Bit indices name the four per-flow state memories and the three retire handshakes.
package tcp_pkg;

  typedef enum logic [2:0] {
    ST_READY,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_CALC,
    ST_OUTPUT
  } tcp_tx_ctrl_state_e;

  localparam int RD_TAIL  = 0;
  localparam int RD_TX    = 1;
  localparam int RD_RX    = 2;
  localparam int RD_TUPLE = 3;

  localparam int OUT_WR  = 0;
  localparam int OUT_CMD = 1;
  localparam int OUT_PKT = 2;

endpackage

// File: rtl/val_rdy_done_tracker.sv
// Bank of N independent valid/ready handshakes: each lane holds val until accepted once.
// Lanes marked skip count as done; the bank self-clears in the cycle all lanes finish.
module val_rdy_done_tracker #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] skip,
  input  logic [N-1:0] rdy,
  output logic [N-1:0] val,
  output logic         all_done
);

  logic [N-1:0] done_q;
  logic [N-1:0] done_d;
  logic [N-1:0] hs;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    val      = '0;
    hs       = '0;
    all_done = 1'b0;
    done_d   = done_q;
    if (en) begin
      val      = ~(done_q | skip);
      hs       = val & rdy;
      all_done = &(done_q | skip | hs);
      done_d   = all_done ? '0 : (done_q | hs);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) assignments only; combinational logic uses blocking (=).
  always_ff @(posedge clk) begin
    if (rst) done_q <= '0;
    else     done_q <= done_d;
  end

endmodule

// File: rtl/tcp_tx_ctrl.sv
// TCP TX protocol-calc control FSM: one flow in flight, reads per-flow state,
// strobes the datapath, then retires via write-back, scheduler command and optional packet.
module tcp_tx_ctrl
  import tcp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_tx_req_val,
  output logic             sched_tx_req_rdy,
  output logic [3:0]       rd_req_val,
  input  logic [3:0]       rd_req_rdy,
  input  logic [3:0]       rd_resp_val,
  output logic [3:0]       rd_resp_rdy,
  output logic             next_tx_state_wr_req_val,
  input  logic             next_tx_state_wr_req_rdy,
  output logic             tx_sched_update_cmd_val,
  input  logic             tx_sched_update_cmd_rdy,
  output logic             proto_calc_tx_val,
  input  logic             proto_calc_tx_rdy,
  output logic             ctrl_datap_store_flowid,
  output logic             ctrl_datap_store_state,
  output logic             ctrl_datap_store_tuple,
  output logic             ctrl_datap_store_calc,
  input  logic             datap_ctrl_produce_pkt,
  output logic             tx_ctrl_busy,
  output logic [CNT_W-1:0] tx_ctrl_pkt_cnt
);

  tcp_tx_ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic       rd_en, rd_all_done;
  logic       out_en, out_all_done;
  logic [2:0] out_val;
  logic       pkt_hs;

  val_rdy_done_tracker #(.N(4)) u_rd_bank (
    .clk      (clk),
    .rst      (rst),
    .en       (rd_en),
    .skip     (4'b0000),
    .rdy      (rd_req_rdy),
    .val      (rd_req_val),
    .all_done (rd_all_done)
  );

  // Without a packet to emit, the packet lane is skipped and counts as done.
  val_rdy_done_tracker #(.N(3)) u_out_bank (
    .clk      (clk),
    .rst      (rst),
    .en       (out_en),
    .skip     ({~datap_ctrl_produce_pkt, 2'b00}),
    .rdy      ({proto_calc_tx_rdy, tx_sched_update_cmd_rdy, next_tx_state_wr_req_rdy}),
    .val      (out_val),
    .all_done (out_all_done)
  );

  assign next_tx_state_wr_req_val = out_val[OUT_WR];
  assign tx_sched_update_cmd_val  = out_val[OUT_CMD];
  assign proto_calc_tx_val        = out_val[OUT_PKT];
  assign pkt_hs                   = proto_calc_tx_val & proto_calc_tx_rdy;
  assign tx_ctrl_busy             = (state_q != ST_READY);
  assign tx_ctrl_pkt_cnt          = pkt_cnt_q;

  always_comb begin
    state_d                 = state_q;
    sched_tx_req_rdy        = 1'b0;
    rd_resp_rdy             = 4'b0000;
    ctrl_datap_store_flowid = 1'b0;
    ctrl_datap_store_state  = 1'b0;
    ctrl_datap_store_tuple  = 1'b0;
    ctrl_datap_store_calc   = 1'b0;
    rd_en                   = 1'b0;
    out_en                  = 1'b0;
    unique case (state_q)
      ST_READY: begin
        sched_tx_req_rdy        = 1'b1;
        ctrl_datap_store_flowid = sched_tx_req_val;
        if (sched_tx_req_val) state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        rd_en = 1'b1;
        if (rd_all_done) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        // Responses are consumed only as a complete set; partial ones stay in the memories.
        if (&rd_resp_val) begin
          rd_resp_rdy            = 4'b1111;
          ctrl_datap_store_state = 1'b1;
          ctrl_datap_store_tuple = 1'b1;
          state_d                = ST_CALC;
        end
      end
      ST_CALC: begin
        ctrl_datap_store_calc = 1'b1;
        state_d               = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        out_en = 1'b1;
        if (out_all_done) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  assign pkt_cnt_d = pkt_cnt_q + {{(CNT_W-1){1'b0}}, pkt_hs};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_READY;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Directed self-checking bench for tcp_tx_ctrl; a narrow counter makes the wrap reachable.
module tb_tcp_tx_ctrl;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             sched_tx_req_val;
  logic             sched_tx_req_rdy;
  logic [3:0]       rd_req_val;
  logic [3:0]       rd_req_rdy;
  logic [3:0]       rd_resp_val;
  logic [3:0]       rd_resp_rdy;
  logic             wr_val, wr_rdy;
  logic             cmd_val, cmd_rdy;
  logic             pkt_val, pkt_rdy;
  logic             st_flowid, st_state, st_tuple, st_calc;
  logic             produce_pkt;
  logic             busy;
  logic [CNT_W-1:0] pkt_cnt;

  int passed = 0;
  int total  = 0;

  tcp_tx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .sched_tx_req_val         (sched_tx_req_val),
    .sched_tx_req_rdy         (sched_tx_req_rdy),
    .rd_req_val               (rd_req_val),
    .rd_req_rdy               (rd_req_rdy),
    .rd_resp_val              (rd_resp_val),
    .rd_resp_rdy              (rd_resp_rdy),
    .next_tx_state_wr_req_val (wr_val),
    .next_tx_state_wr_req_rdy (wr_rdy),
    .tx_sched_update_cmd_val  (cmd_val),
    .tx_sched_update_cmd_rdy  (cmd_rdy),
    .proto_calc_tx_val        (pkt_val),
    .proto_calc_tx_rdy        (pkt_rdy),
    .ctrl_datap_store_flowid  (st_flowid),
    .ctrl_datap_store_state   (st_state),
    .ctrl_datap_store_tuple   (st_tuple),
    .ctrl_datap_store_calc    (st_calc),
    .datap_ctrl_produce_pkt   (produce_pkt),
    .tx_ctrl_busy             (busy),
    .tx_ctrl_pkt_cnt          (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One request through an ideal environment: READY, RD_REQ, RD_RESP, CALC, OUTPUT.
  task automatic run_fast(input logic produce);
    produce_pkt      = produce;
    sched_tx_req_val = 1'b1;
    tick();
    sched_tx_req_val = 1'b0;
    tick();
    rd_resp_val = 4'b1111;
    tick();
    rd_resp_val = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    rst              = 1'b1;
    sched_tx_req_val = 1'b0;
    rd_req_rdy       = 4'b1111;
    rd_resp_val      = 4'b0000;
    wr_rdy           = 1'b1;
    cmd_rdy          = 1'b1;
    pkt_rdy          = 1'b1;
    produce_pkt      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();

    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sched_rdy", 32'(sched_tx_req_rdy), 32'd1);
    check("reset_rd_req_val", 32'(rd_req_val), 32'h0);
    check("reset_out_vals", {29'd0, wr_val, cmd_val, pkt_val}, 32'd0);
    check("reset_cnt", 32'(pkt_cnt), 32'd0);

    // Ideal path, cycle 0..5.
    sched_tx_req_val = 1'b1;
    settle();
    check("c0_store_flowid", 32'(st_flowid), 32'd1);
    tick();
    sched_tx_req_val = 1'b0;
    settle();
    check("c1_rd_req_val", 32'(rd_req_val), 32'hF);
    check("c1_no_store", {28'd0, st_flowid, st_state, st_tuple, st_calc}, 32'd0);
    tick();
    rd_resp_val = 4'b1111;
    settle();
    check("c2_resp_rdy", 32'(rd_resp_rdy), 32'hF);
    check("c2_store_state_tuple", {30'd0, st_state, st_tuple}, 32'd3);
    tick();
    rd_resp_val = 4'b0000;
    settle();
    check("c3_store_calc", 32'(st_calc), 32'd1);
    tick();
    check("c4_out_vals", {29'd0, wr_val, cmd_val, pkt_val}, 32'd7);
    check("c4_busy", 32'(busy), 32'd1);
    tick();
    check("c5_sched_rdy", 32'(sched_tx_req_rdy), 32'd1);
    check("c5_cnt", 32'(pkt_cnt), 32'd1);

    // Staggered read requests, partial responses, no packet.
    produce_pkt      = 1'b0;
    sched_tx_req_val = 1'b1;
    tick();
    sched_tx_req_val = 1'b0;
    rd_req_rdy       = 4'b0001;
    settle();
    check("stag_val0", 32'(rd_req_val), 32'hF);
    tick();
    rd_req_rdy = 4'b0100;
    settle();
    check("stag_val1", 32'(rd_req_val), 32'hE);
    tick();
    rd_req_rdy = 4'b1010;
    settle();
    check("stag_val2", 32'(rd_req_val), 32'hA);
    tick();
    rd_req_rdy  = 4'b1111;
    rd_resp_val = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("partial_rd_req_val", 32'(rd_req_val), 32'h0);
      check("partial_resp_rdy", 32'(rd_resp_rdy), 32'h0);
      check("partial_no_store", {30'd0, st_state, st_tuple}, 32'd0);
      tick();
    end
    rd_resp_val = 4'b1111;
    settle();
    check("full_resp_rdy", 32'(rd_resp_rdy), 32'hF);
    check("full_store_state", 32'(st_state), 32'd1);
    tick();
    rd_resp_val = 4'b0000;
    settle();
    check("once_store_state", 32'(st_state), 32'd0);
    check("np_calc", 32'(st_calc), 32'd1);
    tick();
    check("np_out_vals", {29'd0, wr_val, cmd_val, pkt_val}, 32'b110);
    tick();
    check("np_ready", 32'(busy), 32'd0);
    check("np_cnt_unchanged", 32'(pkt_cnt), 32'd1);

    // Downstream stalls the packet for 10 cycles.
    produce_pkt      = 1'b1;
    pkt_rdy          = 1'b0;
    sched_tx_req_val = 1'b1;
    tick();
    sched_tx_req_val = 1'b0;
    tick();
    rd_resp_val = 4'b1111;
    tick();
    rd_resp_val = 4'b0000;
    tick();
    check("stall_first_vals", {29'd0, wr_val, cmd_val, pkt_val}, 32'd7);
    for (int i = 1; i < 10; i++) begin
      tick();
      check("stall_held_vals", {29'd0, wr_val, cmd_val, pkt_val}, 32'b001);
    end
    check("stall_busy", 32'(busy), 32'd1);
    pkt_rdy = 1'b1;
    tick();
    check("stall_ready", 32'(busy), 32'd0);
    check("stall_cnt", 32'(pkt_cnt), 32'd2);

    // Reset while waiting for responses.
    sched_tx_req_val = 1'b1;
    tick();
    sched_tx_req_val = 1'b0;
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vals", {25'd0, rd_req_val, wr_val, cmd_val, pkt_val}, 32'd0);
    check("rst_cnt", 32'(pkt_cnt), 32'd0);
    run_fast(1'b1);
    check("post_rst_cnt", 32'(pkt_cnt), 32'd1);
    check("post_rst_ready", 32'(busy), 32'd0);

    // Counter wrap: bring it to 2^CNT_W-1, then one more packet.
    for (int i = 0; i < 6; i++) run_fast(1'b1);
    check("cnt_max", 32'(pkt_cnt), 32'd7);
    run_fast(1'b1);
    check("cnt_wrap", 32'(pkt_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
